// File: rtl/cpu_bus_arbiter_if.sv
// Avalon-MM style port bundle shared by the two CPU hosts and the memory agent.
// slave_ro is the arbiter-side view of a read-only host (no write strobe/data).
interface cpu_bus_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]   address;
  logic                read;
  logic                write;
  logic [DATA_W/8-1:0] byteenable;
  logic [DATA_W-1:0]   host_to_agent;
  logic [DATA_W-1:0]   agent_to_host;
  logic                waitrequest;
  logic                readdatavalid;

  modport master (
    output address, read, write, byteenable, host_to_agent,
    input  agent_to_host, waitrequest, readdatavalid
  );

  modport slave (
    input  address, read, write, byteenable, host_to_agent,
    output agent_to_host, waitrequest, readdatavalid
  );

  modport slave_ro (
    input  address, read, byteenable,
    output agent_to_host, waitrequest, readdatavalid
  );
endinterface

// File: rtl/cpu_bus_arbiter.sv
// Round-robin arbiter: instruction-fetch and data hosts share one memory agent,
// one outstanding transaction at a time.
module cpu_bus_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  cpu_bus_arbiter_if.slave_ro      i_bus,
  cpu_bus_arbiter_if.slave         d_bus,
  cpu_bus_arbiter_if.master        m_bus,
  output logic                     busy,
  output logic                     owner
);
  typedef enum logic [1:0] {IDLE, GRANT_I, GRANT_D, RDWAIT} state_t;

  state_t state_q, state_d;
  logic   owner_q, owner_d;
  logic   last_q,  last_d;   // 1 = data host was granted last
  logic   i_req, d_req;

  assign i_req = i_bus.read;
  assign d_req = d_bus.read | d_bus.write;

  assign busy  = (state_q != IDLE);
  assign owner = owner_q;

  // Read data is broadcast; only readdatavalid is steered to the owner.
  assign i_bus.agent_to_host = m_bus.agent_to_host;
  assign d_bus.agent_to_host = m_bus.agent_to_host;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    unique case (state_q)
      IDLE: begin
        if (i_req && (!d_req || last_q)) begin
          state_d = GRANT_I;
          owner_d = 1'b0;
          last_d  = 1'b0;
        end else if (d_req) begin
          state_d = GRANT_D;
          owner_d = 1'b1;
          last_d  = 1'b1;
        end
      end
      GRANT_I: begin
        if (!i_req)                     state_d = IDLE;
        else if (!m_bus.waitrequest)    state_d = m_bus.readdatavalid ? IDLE : RDWAIT;
      end
      GRANT_D: begin
        if (!d_req)                     state_d = IDLE;
        else if (!m_bus.waitrequest)    state_d = (d_bus.write || m_bus.readdatavalid) ? IDLE : RDWAIT;
      end
      RDWAIT: begin
        if (m_bus.readdatavalid)        state_d = IDLE;
      end
      default:                          state_d = IDLE;
    endcase
  end

  always_comb begin
    m_bus.address       = {ADDR_W{1'b0}};
    m_bus.read          = 1'b0;
    m_bus.write         = 1'b0;
    m_bus.byteenable    = {(DATA_W/8){1'b0}};
    m_bus.host_to_agent = {DATA_W{1'b0}};
    i_bus.waitrequest   = 1'b1;
    i_bus.readdatavalid = 1'b0;
    d_bus.waitrequest   = 1'b1;
    d_bus.readdatavalid = 1'b0;
    unique case (state_q)
      GRANT_I: begin
        m_bus.address       = i_bus.address;
        m_bus.read          = i_bus.read;
        m_bus.byteenable    = i_bus.byteenable;
        i_bus.waitrequest   = m_bus.waitrequest;
        i_bus.readdatavalid = i_bus.read & ~m_bus.waitrequest & m_bus.readdatavalid;
      end
      GRANT_D: begin
        // A simultaneous read+write from the data host issues only the write.
        m_bus.address       = d_bus.address;
        m_bus.read          = d_bus.read & ~d_bus.write;
        m_bus.write         = d_bus.write;
        m_bus.byteenable    = d_bus.byteenable;
        m_bus.host_to_agent = d_bus.host_to_agent;
        d_bus.waitrequest   = m_bus.waitrequest;
        d_bus.readdatavalid = d_bus.read & ~d_bus.write & ~m_bus.waitrequest & m_bus.readdatavalid;
      end
      RDWAIT: begin
        if (owner_q) begin
          d_bus.waitrequest   = 1'b0;
          d_bus.readdatavalid = m_bus.readdatavalid;
        end else begin
          i_bus.waitrequest   = 1'b0;
          i_bus.readdatavalid = m_bus.readdatavalid;
        end
      end
      default: ;
    endcase
  end
endmodule

// File: doc/cpu_bus_arbiter.md
# cpu_bus_arbiter

Two-host to one-agent Avalon-MM arbiter that lets the CPU's instruction-fetch port (read-only) and data port (read/write) share a single memory agent. It sits between the CPU and the unified memory, serialises transactions, and allows one outstanding transaction at a time. Round-robin arbitration prevents either port from starving the other.

## Interface
Parameters:
- ADDR_W, 32, address width of all ports
- DATA_W, 32, data width; byteenable width is DATA_W/8

Ports:
- clk  in  1  clock; single clock domain
- rst  in  1  reset, synchronous, active-high
- i_address  in  ADDR_W  instruction host address
- i_read  in  1  instruction host read request
- i_byteenable  in  DATA_W/8  instruction host byte enables
- i_agent_to_host  out  DATA_W  read data to instruction host
- i_waitrequest  out  1  stall to instruction host
- i_readdatavalid  out  1  read data valid to instruction host
- d_address  in  ADDR_W  data host address
- d_read  in  1  data host read request
- d_write  in  1  data host write request
- d_byteenable  in  DATA_W/8  data host byte enables
- d_host_to_agent  in  DATA_W  data host write data
- d_agent_to_host  out  DATA_W  read data to data host
- d_waitrequest  out  1  stall to data host
- d_readdatavalid  out  1  read data valid to data host
- m_address, m_read, m_write, m_byteenable, m_host_to_agent  out  ADDR_W/1/1/DATA_W/8/DATA_W  shared agent command
- m_agent_to_host  in  DATA_W  agent read data
- m_waitrequest  in  1  agent stall
- m_readdatavalid  in  1  agent read data valid
- busy  out  1  state != IDLE
- owner  out  1  0 = instruction host, 1 = data host (valid when busy)

## Operation
- States: IDLE, GRANT_I, GRANT_D, RDWAIT.
- IDLE: m_read/m_write = 0, m_address/m_byteenable/m_host_to_agent = 0. Requests: i_req = i_read; d_req = d_read | d_write.
  - Only one request asserted: go to that host's GRANT state.
  - Both asserted: grant the host not in last_grant. last_grant resets to data, so the first tie after reset goes to instruction.
  - last_grant updates on every transition into a GRANT state.
- GRANT_x: the owner's address, read, write, byteenable and write data are driven to m_*. The owner's waitrequest = m_waitrequest.
  - Data host with d_read and d_write both set: only the write is issued (m_read = 0).
  - Write accepted (m_write & !m_waitrequest): go to IDLE.
  - Read accepted (m_read & !m_waitrequest): go to RDWAIT. If m_readdatavalid is also set in that cycle, forward it and go to IDLE instead.
  - Owner deasserts its request before acceptance: abort and go to IDLE. Nothing completes.
- RDWAIT: m_read = 0 and m_write = 0. The owner's waitrequest = 0. The owner's readdatavalid = m_readdatavalid. On m_readdatavalid, go to IDLE.
- Non-owner host (and both hosts in IDLE): waitrequest = 1, readdatavalid = 0.
- m_agent_to_host is broadcast to both *_agent_to_host outputs unconditionally. Only readdatavalid is steered.
- m_readdatavalid in IDLE or GRANT_x (except the zero-latency case) is ignored.
- A host that still holds its request in the IDLE cycle after completion is a new request and is arbitrated normally. Avoiding a re-issue is the host's responsibility.

## Timing
- State, owner and last_grant are registered. m_* outputs and host waitrequest/readdatavalid are combinational from the state and the owner's or agent's inputs.
- Arbitration latency: a request first seen in IDLE at cycle N is presented on m_* at cycle N+1.
- Turnaround: at least one IDLE cycle between consecutive transactions. Minimum write = 2 cycles (IDLE, GRANT). Minimum read = 2 cycles with zero-latency readdatavalid, otherwise 3 + agent latency.
- Reset, applied at any cycle including mid-read: next state IDLE, last_grant = data. A readdatavalid returning after reset is dropped.
- Reset output values: busy 0, owner 0, m_read 0, m_write 0, m_address 0, m_byteenable 0, m_host_to_agent 0, i/d_waitrequest 1, i/d_readdatavalid 0.

## Test plan
- Instruction-only read at 0x100, agent waitrequest for 2 cycles then readdatavalid after 3 cycles with data 0x00000013 -> m_read high for exactly 3 cycles, i_readdatavalid pulses once with i_agent_to_host = 0x00000013, d_waitrequest held 1 throughout.
- Data write of 0xDEADBEEF to 0x2000 with byteenable 4'b1111 and no agent stall -> m_write high for 1 cycle with matching address and data, d_waitrequest low in that cycle, state back to IDLE next cycle.
- Both hosts request on the same cycle right after reset -> instruction granted first, data granted on the following arbitration, owner sequence 0, 1.
- Both hosts hold requests continuously for 4 transactions -> grants alternate I, D, I, D and neither host receives two grants in a row.
- rst asserted while in RDWAIT, agent returns readdatavalid 2 cycles later -> both hosts see readdatavalid 0, busy 0, all outputs at reset values.
- Data host asserts d_read and d_write together -> only m_write is issued, m_read stays 0.
